// File: rtl/wb_pipe_skid_pkg.sv
// Shared widths, limits and state encoding for the MEM/WB skid pipeline stage.
package wb_pipe_skid_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned WB_MAX_CH  = 4;

    typedef enum logic [1:0] {
        WBS_EMPTY = 2'd0,
        WBS_FULL  = 2'd1,
        WBS_SKID  = 2'd2
    } wbs_state_e;

endpackage : wb_pipe_skid_pkg

// File: rtl/wb_pipe_skid_slot.sv
// Storage primitives: enabled flop with async reset, and one NUM_CH-wide write-back entry.

module gen_dffr #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Enabled register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : gen_dffr

module wb_slot_reg
    import wb_pipe_skid_pkg::*;
#(
    parameter int unsigned NUM_CH = 1,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DATA_W = REG_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     clr,
    input  logic [NUM_CH-1:0]        d_en,
    input  logic [NUM_CH*ADDR_W-1:0] d_addr,
    input  logic [NUM_CH*DATA_W-1:0] d_data,
    output logic                     q_valid,
    output logic [NUM_CH-1:0]        q_en,
    output logic [NUM_CH*ADDR_W-1:0] q_addr,
    output logic [NUM_CH*DATA_W-1:0] q_data
);

    logic [NUM_CH-1:0] en_masked_c;
    logic [NUM_CH-1:0] en_next_c;

    // Enables to x0 are dropped at load time so stored en is already write-qualified.
    always_comb begin
        en_masked_c = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            en_masked_c[k] = d_en[k] & (d_addr[k*ADDR_W +: ADDR_W] != '0);
        end
    end

    // A cleared entry also drops its enables, so en is zero whenever valid is zero.
    assign en_next_c = load ? en_masked_c : '0;

    gen_dffr #(.W(1)) u_valid (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load | clr),
        .d     (load),
        .q     (q_valid)
    );

    gen_dffr #(.W(NUM_CH)) u_en (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load | clr),
        .d     (en_next_c),
        .q     (q_en)
    );

    gen_dffr #(.W(NUM_CH*ADDR_W)) u_addr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load),
        .d     (d_addr),
        .q     (q_addr)
    );

    gen_dffr #(.W(NUM_CH*DATA_W)) u_data (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load),
        .d     (d_data),
        .q     (q_data)
    );

endmodule : wb_slot_reg

// File: rtl/wb_pipe_skid.sv
// MEM/WB pipeline stage: NUM_CH write-back channels, 2-entry skid buffer, flush/hold, EX forwarding.
module wb_pipe_skid
    import wb_pipe_skid_pkg::*;
#(
    parameter int unsigned NUM_CH = 1,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DATA_W = REG_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     hold_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [NUM_CH-1:0]        in_wreg_en_i,
    input  logic [NUM_CH*ADDR_W-1:0] in_wreg_addr_i,
    input  logic [NUM_CH*DATA_W-1:0] in_wreg_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [NUM_CH-1:0]        wb_wreg_en_o,
    output logic [NUM_CH*ADDR_W-1:0] wb_wreg_addr_o,
    output logic [NUM_CH*DATA_W-1:0] wb_wreg_data_o,
    input  logic [ADDR_W-1:0]        fwd_addr_i,
    output logic                     fwd_hit_o,
    output logic [DATA_W-1:0]        fwd_data_o
);

    wbs_state_e state_q;
    wbs_state_e state_nxt;

    logic in_fire_c;
    logic out_fire_c;
    logic main_load_c;
    logic main_clr_c;
    logic main_from_skid_c;
    logic skid_load_c;
    logic skid_clr_c;

    logic                     skid_valid;
    logic [NUM_CH-1:0]        skid_en;
    logic [NUM_CH*ADDR_W-1:0] skid_addr;
    logic [NUM_CH*DATA_W-1:0] skid_data;

    logic [NUM_CH-1:0]        main_d_en_c;
    logic [NUM_CH*ADDR_W-1:0] main_d_addr_c;
    logic [NUM_CH*DATA_W-1:0] main_d_data_c;

    assign in_fire_c  = in_valid_i & in_ready_o & ~hold_i & ~flush_i;
    assign out_fire_c = out_valid_o & out_ready_i & ~hold_i & ~flush_i;

    // State register and registered upstream ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WBS_EMPTY;
            in_ready_o <= 1'b1;
        end else begin
            state_q    <= state_nxt;
            in_ready_o <= (state_nxt != WBS_SKID);
        end
    end

    // Next-state and entry load/clear decode; flush overrides everything, hold suppresses both fires.
    always_comb begin
        state_nxt        = state_q;
        main_load_c      = 1'b0;
        main_clr_c       = 1'b0;
        main_from_skid_c = 1'b0;
        skid_load_c      = 1'b0;
        skid_clr_c       = 1'b0;
        if (flush_i) begin
            state_nxt  = WBS_EMPTY;
            main_clr_c = 1'b1;
            skid_clr_c = 1'b1;
        end else begin
            case (state_q)
                WBS_EMPTY: begin
                    if (in_fire_c) begin
                        state_nxt   = WBS_FULL;
                        main_load_c = 1'b1;
                    end
                end
                WBS_FULL: begin
                    if (in_fire_c && out_fire_c) begin
                        main_load_c = 1'b1;
                    end else if (out_fire_c) begin
                        state_nxt  = WBS_EMPTY;
                        main_clr_c = 1'b1;
                    end else if (in_fire_c) begin
                        state_nxt   = WBS_SKID;
                        skid_load_c = 1'b1;
                    end
                end
                WBS_SKID: begin
                    if (out_fire_c) begin
                        state_nxt        = WBS_FULL;
                        main_load_c      = 1'b1;
                        main_from_skid_c = 1'b1;
                        skid_clr_c       = 1'b1;
                    end
                end
                default: begin
                    state_nxt  = WBS_EMPTY;
                    main_clr_c = 1'b1;
                    skid_clr_c = 1'b1;
                end
            endcase
        end
    end

    // Main entry refills from skid when draining a two-deep stage, else from MEM.
    always_comb begin
        main_d_en_c   = in_wreg_en_i;
        main_d_addr_c = in_wreg_addr_i;
        main_d_data_c = in_wreg_data_i;
        if (main_from_skid_c) begin
            main_d_en_c   = skid_en;
            main_d_addr_c = skid_addr;
            main_d_data_c = skid_data;
        end
    end

    wb_slot_reg #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (main_load_c),
        .clr     (main_clr_c),
        .d_en    (main_d_en_c),
        .d_addr  (main_d_addr_c),
        .d_data  (main_d_data_c),
        .q_valid (out_valid_o),
        .q_en    (wb_wreg_en_o),
        .q_addr  (wb_wreg_addr_o),
        .q_data  (wb_wreg_data_o)
    );

    wb_slot_reg #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (skid_load_c),
        .clr     (skid_clr_c),
        .d_en    (in_wreg_en_i),
        .d_addr  (in_wreg_addr_i),
        .d_data  (in_wreg_data_i),
        .q_valid (skid_valid),
        .q_en    (skid_en),
        .q_addr  (skid_addr),
        .q_data  (skid_data)
    );

    // Forwarding lookup: later assignments win, so skid beats main and higher channels beat lower.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        if (fwd_addr_i != '0) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (out_valid_o && wb_wreg_en_o[k] &&
                    (wb_wreg_addr_o[k*ADDR_W +: ADDR_W] == fwd_addr_i)) begin
                    fwd_hit_o  = 1'b1;
                    fwd_data_o = wb_wreg_data_o[k*DATA_W +: DATA_W];
                end
            end
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (skid_valid && skid_en[k] &&
                    (skid_addr[k*ADDR_W +: ADDR_W] == fwd_addr_i)) begin
                    fwd_hit_o  = 1'b1;
                    fwd_data_o = skid_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule : wb_pipe_skid
